// File: rtl/glm_dispatch_pkg.sv
// Shared types and constants for the GLM op dispatcher: FSM states, opcode
// values, instruction word bundle and a small popcount helper.
package glm_dispatch_pkg;

  localparam int NUM_WORDS = 5;

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_BARRIER = 8'hFE;

  typedef logic [NUM_WORDS-1:0][31:0] regs_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CHECK   = 2'd1,
    S_BARRIER = 2'd2
  } state_e;

  // Decoded instruction class, captured once per instruction in S_CHECK.
  typedef enum logic [1:0] {
    K_NOP      = 2'd0,
    K_DISPATCH = 2'd1,
    K_BARRIER  = 2'd2,
    K_ILLEGAL  = 2'd3
  } kind_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/glm_op_dispatch_if.sv
// Bundle between the dispatcher, its instruction source and the execution units.
// The master modport is the dispatcher's view; slave is the surrounding system.
interface glm_op_dispatch_if
  import glm_dispatch_pkg::*;
#(
  parameter int NUM_UNITS = 4
) ();

  logic                 instr_valid;
  logic                 instr_ready;
  regs_t                instr_regs;
  logic [NUM_UNITS-1:0] unit_start;
  regs_t                unit_regs;
  logic [NUM_UNITS-1:0] unit_done;
  logic [NUM_UNITS-1:0] busy;
  logic                 idle;
  logic [31:0]          retired_count;
  logic                 error;

  modport master (
    input  instr_valid,
    input  instr_regs,
    input  unit_done,
    output instr_ready,
    output unit_start,
    output unit_regs,
    output busy,
    output idle,
    output retired_count,
    output error
  );

  modport slave (
    output instr_valid,
    output instr_regs,
    output unit_done,
    input  instr_ready,
    input  unit_start,
    input  unit_regs,
    input  busy,
    input  idle,
    input  retired_count,
    input  error
  );

endinterface

// File: rtl/glm_op_dispatch.sv
// Single-issue dispatcher: accepts one instruction at a time, waits for the
// target unit and its dependency units to be free, then pulses that unit's start.
module glm_op_dispatch
  import glm_dispatch_pkg::*;
#(
  parameter int NUM_UNITS = 4
) (
  input logic              clk,
  input logic              reset,
  glm_op_dispatch_if.master bus
);

  state_e               state_q;
  regs_t                regs_q;
  regs_t                unit_regs_q;
  logic                 decoded_q;
  kind_e                kind_q;
  logic [NUM_UNITS-1:0] tgt_q;
  logic [NUM_UNITS-1:0] dep_q;
  logic [NUM_UNITS-1:0] busy_q;
  logic [NUM_UNITS-1:0] start_q;
  logic [31:0]          retired_q;
  logic                 error_q;

  logic [7:0]           opcode;
  kind_e                kind_d;
  logic [NUM_UNITS-1:0] tgt_d;
  logic [NUM_UNITS-1:0] done_ok;
  logic [NUM_UNITS-1:0] done_bad;
  logic [NUM_UNITS-1:0] busy_after_done;
  logic                 can_issue;

  // Decode of the latched instruction; registered on the first S_CHECK cycle.
  always_comb begin
    opcode = regs_q[0][7:0];
    tgt_d  = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      tgt_d[i] = (opcode == 8'(i + 1));
    end
    if (opcode == OP_NOP) begin
      kind_d = K_NOP;
    end else if (opcode == OP_BARRIER) begin
      kind_d = K_BARRIER;
    end else if (|tgt_d) begin
      kind_d = K_DISPATCH;
    end else begin
      kind_d = K_ILLEGAL;
    end
  end

  assign done_ok         = bus.unit_done & busy_q;
  assign done_bad        = bus.unit_done & ~busy_q;
  assign busy_after_done = busy_q & ~bus.unit_done;
  // Issue decision looks at registered busy, so a same-cycle done costs one cycle.
  assign can_issue       = ((tgt_q | dep_q) & busy_q) == '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      regs_q      <= '0;
      unit_regs_q <= '0;
      decoded_q   <= 1'b0;
      kind_q      <= K_NOP;
      tgt_q       <= '0;
      dep_q       <= '0;
      busy_q      <= '0;
      start_q     <= '0;
      retired_q   <= '0;
      error_q     <= 1'b0;
    end else begin
      start_q   <= '0;
      busy_q    <= busy_after_done;
      retired_q <= retired_q + 32'(popcount8(8'(done_ok)));
      if (|done_bad) begin
        error_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (bus.instr_valid) begin
            regs_q    <= bus.instr_regs;
            decoded_q <= 1'b0;
            state_q   <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (!decoded_q) begin
            kind_q    <= kind_d;
            tgt_q     <= tgt_d;
            dep_q     <= regs_q[0][8 +: NUM_UNITS];
            decoded_q <= 1'b1;
          end else begin
            case (kind_q)
              K_NOP:     state_q <= S_IDLE;
              K_BARRIER: state_q <= S_BARRIER;
              K_ILLEGAL: begin
                error_q <= 1'b1;
                state_q <= S_IDLE;
              end
              default: begin
                if (can_issue) begin
                  start_q     <= tgt_q;
                  unit_regs_q <= regs_q;
                  busy_q      <= busy_after_done | tgt_q;
                  state_q     <= S_IDLE;
                end
              end
            endcase
          end
        end

        // Leave as soon as the post-done busy vector is empty.
        S_BARRIER: begin
          if (busy_after_done == '0) begin
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.instr_ready   = (state_q == S_IDLE);
  assign bus.idle          = (state_q == S_IDLE) && (busy_q == '0);
  assign bus.unit_start    = start_q;
  assign bus.unit_regs     = unit_regs_q;
  assign bus.busy          = busy_q;
  assign bus.retired_count = retired_q;
  assign bus.error         = error_q;

endmodule

// File: tb/tb_glm_op_dispatch.sv
// Directed bench for glm_op_dispatch: dispatch latency, busy/dependency stalls,
// barrier, error cases and mid-operation reset, checked with immediate assertions.
module tb_glm_op_dispatch;
  import glm_dispatch_pkg::*;

  localparam int NU = 4;

  logic  clk   = 1'b0;
  logic  reset = 1'b1;
  int    assertCount = 0;
  int    failCount   = 0;
  regs_t words;

  glm_op_dispatch_if #(.NUM_UNITS(NU)) bus ();

  glm_op_dispatch #(.NUM_UNITS(NU)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkRegs(input string tag, input regs_t observed, input regs_t expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Offers one instruction and returns just after its handshake edge.
  task automatic applyStimulus(input logic [31:0] w0, input logic [31:0] salt);
    words[0] = w0;
    for (int i = 1; i < NUM_WORDS; i++) begin
      words[i] = salt + 32'(i);
    end
    bus.instr_regs  = words;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
  endtask

  task automatic pulseDone(input logic [NU-1:0] d);
    bus.unit_done = d;
    tick();
    bus.unit_done = '0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_regs  = '0;
    bus.unit_done   = '0;
    words           = '0;

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checkOutput("rst_ready", 32'(bus.instr_ready), 32'd1);
    checkOutput("rst_idle",  32'(bus.idle),        32'd1);
    checkOutput("rst_busy",  32'(bus.busy),        32'h0);
    checkOutput("rst_start", 32'(bus.unit_start),  32'h0);
    checkOutput("rst_count", bus.retired_count,    32'd0);
    checkOutput("rst_error", 32'(bus.error),       32'd0);
    checkRegs("rst_regs", bus.unit_regs, '0);

    // Plain dispatch to unit 1, start two cycles after the handshake
    applyStimulus(32'h0000_0002, 32'hA5A5_0000);
    checkOutput("t1_ready_low", 32'(bus.instr_ready), 32'd0);
    tick();
    checkOutput("t1_start_early", 32'(bus.unit_start), 32'h0);
    tick();
    checkOutput("t1_start", 32'(bus.unit_start), 32'h2);
    checkRegs("t1_regs", bus.unit_regs, words);
    checkOutput("t1_busy",  32'(bus.busy),        32'h2);
    checkOutput("t1_ready", 32'(bus.instr_ready), 32'd1);
    checkOutput("t1_idle",  32'(bus.idle),        32'd0);
    tick();
    checkOutput("t1_start_pulse", 32'(bus.unit_start), 32'h0);
    checkRegs("t1_regs_hold", bus.unit_regs, words);
    pulseDone(4'b0010);
    checkOutput("t1_busy_clr", 32'(bus.busy),    32'h0);
    checkOutput("t1_count",    bus.retired_count, 32'd1);
    checkOutput("t1_idle_end", 32'(bus.idle),     32'd1);

    // NOP changes nothing
    applyStimulus(32'h0000_0000, 32'h1111_0000);
    tick();
    tick();
    checkOutput("nop_start", 32'(bus.unit_start),  32'h0);
    checkOutput("nop_ready", 32'(bus.instr_ready), 32'd1);
    checkOutput("nop_count", bus.retired_count,    32'd1);
    checkOutput("nop_error", 32'(bus.error),       32'd0);

    // Second op to a busy unit waits; a done in the check cycle costs one cycle
    applyStimulus(32'h0000_0001, 32'hB0B0_0000);
    tick();
    tick();
    checkOutput("t2_first_start", 32'(bus.unit_start), 32'h1);
    applyStimulus(32'h0000_0001, 32'hB1B1_0000);
    tick();
    tick();
    checkOutput("t2_blocked_start", 32'(bus.unit_start),  32'h0);
    checkOutput("t2_blocked_ready", 32'(bus.instr_ready), 32'd0);
    tick();
    checkOutput("t2_still_blocked", 32'(bus.unit_start), 32'h0);
    pulseDone(4'b0001);
    checkOutput("t2_done_edge_start", 32'(bus.unit_start),  32'h0);
    checkOutput("t2_done_edge_busy",  32'(bus.busy),        32'h0);
    checkOutput("t2_done_edge_ready", 32'(bus.instr_ready), 32'd0);
    checkOutput("t2_done_edge_count", bus.retired_count,    32'd2);
    tick();
    checkOutput("t2_issue_start", 32'(bus.unit_start), 32'h1);
    checkOutput("t2_issue_busy",  32'(bus.busy),       32'h1);
    checkRegs("t2_issue_regs", bus.unit_regs, words);
    pulseDone(4'b0001);
    checkOutput("t2_count", bus.retired_count, 32'd3);

    // Opcode 3 with dependency on unit 0
    applyStimulus(32'h0000_0001, 32'hC0C0_0000);
    tick();
    tick();
    checkOutput("t3_unit0_busy", 32'(bus.busy), 32'h1);
    applyStimulus(32'h0000_0103, 32'hC3C3_0000);
    tick();
    tick();
    checkOutput("t3_dep_hold", 32'(bus.unit_start), 32'h0);
    tick();
    checkOutput("t3_dep_hold2", 32'(bus.unit_start), 32'h0);
    pulseDone(4'b0001);
    checkOutput("t3_done_start", 32'(bus.unit_start), 32'h0);
    checkOutput("t3_done_count", bus.retired_count,   32'd4);
    tick();
    checkOutput("t3_start", 32'(bus.unit_start), 32'h4);
    checkOutput("t3_busy",  32'(bus.busy),       32'h4);
    checkRegs("t3_regs", bus.unit_regs, words);
    pulseDone(4'b0100);
    checkOutput("t3_count", bus.retired_count, 32'd5);

    // Barrier with two busy units retiring on the same edge
    applyStimulus(32'h0000_0001, 32'hD0D0_0000);
    tick();
    tick();
    applyStimulus(32'h0000_0002, 32'hD1D1_0000);
    tick();
    tick();
    checkOutput("t4_busy2", 32'(bus.busy), 32'h3);
    applyStimulus(32'h0000_00FE, 32'hD2D2_0000);
    tick();
    tick();
    checkOutput("t4_barrier_ready", 32'(bus.instr_ready), 32'd0);
    checkOutput("t4_barrier_idle",  32'(bus.idle),        32'd0);
    tick();
    checkOutput("t4_barrier_wait", 32'(bus.instr_ready), 32'd0);
    pulseDone(4'b0011);
    checkOutput("t4_count", bus.retired_count,    32'd7);
    checkOutput("t4_busy",  32'(bus.busy),        32'h0);
    checkOutput("t4_ready", 32'(bus.instr_ready), 32'd1);
    checkOutput("t4_idle",  32'(bus.idle),        32'd1);

    // Spurious done while idle, then illegal opcode after a reset
    pulseDone(4'b1000);
    checkOutput("t5_spurious_error", 32'(bus.error),    32'd1);
    checkOutput("t5_spurious_count", bus.retired_count, 32'd7);
    tick();
    checkOutput("t5_error_sticky", 32'(bus.error), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t5_rst_error", 32'(bus.error),    32'd0);
    checkOutput("t5_rst_count", bus.retired_count, 32'd0);
    applyStimulus(32'h0000_007F, 32'hE0E0_0000);
    tick();
    checkOutput("t5_err_not_yet", 32'(bus.error), 32'd0);
    tick();
    checkOutput("t5_illegal_error", 32'(bus.error),       32'd1);
    checkOutput("t5_illegal_start", 32'(bus.unit_start),  32'h0);
    checkOutput("t5_illegal_ready", 32'(bus.instr_ready), 32'd1);
    checkOutput("t5_illegal_count", bus.retired_count,    32'd0);
    checkOutput("t5_illegal_busy",  32'(bus.busy),        32'h0);

    // Reset with unit 1 busy and a blocked instruction in S_CHECK
    applyStimulus(32'h0000_0001, 32'hF0F0_0000);
    tick();
    tick();
    pulseDone(4'b0001);
    checkOutput("t6_pre_count", bus.retired_count, 32'd1);
    applyStimulus(32'h0000_0002, 32'hF1F1_0000);
    tick();
    tick();
    checkOutput("t6_pre_busy", 32'(bus.busy), 32'h2);
    applyStimulus(32'h0000_0002, 32'hF2F2_0000);
    tick();
    tick();
    checkOutput("t6_pending_ready", 32'(bus.instr_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("t6_busy",  32'(bus.busy),        32'h0);
    checkOutput("t6_count", bus.retired_count,    32'd0);
    checkOutput("t6_start", 32'(bus.unit_start),  32'h0);
    checkOutput("t6_ready", 32'(bus.instr_ready), 32'd1);
    checkOutput("t6_idle",  32'(bus.idle),        32'd1);
    checkRegs("t6_regs", bus.unit_regs, '0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("t6_no_start", 32'(bus.unit_start), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
